// File: rtl/mfp_multi_digit_seven_segment_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : mfp_multi_digit_seven_segment_scanner_if
// Brief    : Display-data and pin bundle for the multiplexed 7-segment scanner.
// Revision : 1.0
// ============================================================================
interface mfp_multi_digit_seven_segment_scanner_if #(
    parameter int N_DIGITS = 8,
    parameter int BRIGHT_W = 4
);
    logic [4*N_DIGITS-1:0] number;
    logic [N_DIGITS-1:0]   digit_en;
    logic [N_DIGITS-1:0]   dots;
    logic                  blank_lz;
    logic [BRIGHT_W-1:0]   brightness;
    logic                  update;
    logic [N_DIGITS-1:0]   anodes;
    logic [6:0]            segments;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output number, digit_en, dots, blank_lz, brightness, update,
        input  anodes, segments, dp, frame_done
    );

    modport slave (
        input  number, digit_en, dots, blank_lz, brightness, update,
        output anodes, segments, dp, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/mfp_multi_digit_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
// Module   : mfp_multi_digit_seven_segment_scanner
// Brief    : Time-multiplexed N-digit 7-segment driver with PWM brightness,
//            leading-zero blanking and frame-synchronous shadow updates.
// Revision : 1.0
// ============================================================================
module mfp_multi_digit_seven_segment_scanner #(
    parameter int N_DIGITS    = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int BRIGHT_W    = 4,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    mfp_multi_digit_seven_segment_scanner_if.slave bus
);
    localparam int CNT_W     = $clog2(SCAN_DIV);
    localparam int IDX_W     = $clog2(N_DIGITS);
    localparam int PHASE_LEN = SCAN_DIV >> BRIGHT_W;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_ACT_LOW}};
    localparam logic [6:0]          SEG_OFF  = {7{SEG_ACT_LOW}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  frame_done_q;
    logic [N_DIGITS-1:0]   anodes_q, anodes_d;
    logic [6:0]            segments_q, segments_d;
    logic                  dp_q, dp_d;

    logic [4*N_DIGITS-1:0] stg_num_q, sh_num_q;
    logic [N_DIGITS-1:0]   stg_en_q, sh_en_q;
    logic [N_DIGITS-1:0]   stg_dots_q, sh_dots_q;
    logic                  stg_blz_q, sh_blz_q;
    logic                  pending_q;

    logic                  slot_end;
    logic                  wrap;
    logic [BRIGHT_W-1:0]   phase;
    logic [3:0]            cur_nib;
    logic [N_DIGITS-1:0]   upper_zero;
    logic                  lz_blank;
    logic                  lit;
    logic [6:0]            seg_hi;
    logic [N_DIGITS-1:0]   sel;

    assign slot_end = (cnt_q == CNT_LAST);
    assign wrap     = slot_end && (idx_q == IDX_LAST);
    assign phase    = BRIGHT_W'(cnt_q / CNT_W'(PHASE_LEN));
    assign cur_nib  = sh_num_q[4*int'(idx_q) +: 4];
    assign sel      = N_DIGITS'(1) << idx_q;

    // upper_zero[i]: nibble i and every more significant nibble are zero
    generate
        for (genvar i = 0; i < N_DIGITS; i++) begin : g_upper_zero
            assign upper_zero[i] = (sh_num_q[4*N_DIGITS-1:4*i] == '0);
        end
    endgenerate

    assign lz_blank = sh_blz_q && (idx_q != '0) && upper_zero[idx_q];
    // phase 0 stays dark so the anode switch never overlaps old segment data
    assign lit = (phase != '0) && (phase <= bus.brightness) && sh_en_q[idx_q] && !lz_blank;

    always_comb begin
        seg_hi = 7'h00;
        case (cur_nib)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            default: seg_hi = 7'h71;
        endcase
    end

    always_comb begin
        cnt_d      = slot_end ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (wrap) begin
            idx_d = '0;
        end else if (slot_end) begin
            idx_d = idx_q + 1'b1;
        end
        anodes_d   = lit ? (sel ^ AN_OFF) : AN_OFF;
        segments_d = lit ? (seg_hi ^ SEG_OFF) : SEG_OFF;
        dp_d       = lit ? (sh_dots_q[idx_q] ^ SEG_ACT_LOW) : SEG_ACT_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            anodes_q     <= AN_OFF;
            segments_q   <= SEG_OFF;
            dp_q         <= SEG_ACT_LOW;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= wrap;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
            dp_q         <= dp_d;
        end
    end

    // Shadow only changes on the frame wrap so a frame is never torn
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_num_q  <= '0;
            stg_en_q   <= '0;
            stg_dots_q <= '0;
            stg_blz_q  <= 1'b0;
            sh_num_q   <= '0;
            sh_en_q    <= '0;
            sh_dots_q  <= '0;
            sh_blz_q   <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            if (bus.update) begin
                stg_num_q  <= bus.number;
                stg_en_q   <= bus.digit_en;
                stg_dots_q <= bus.dots;
                stg_blz_q  <= bus.blank_lz;
            end
            if (bus.update && wrap) begin
                sh_num_q  <= bus.number;
                sh_en_q   <= bus.digit_en;
                sh_dots_q <= bus.dots;
                sh_blz_q  <= bus.blank_lz;
                pending_q <= 1'b0;
            end else if (bus.update) begin
                pending_q <= 1'b1;
            end else if (wrap && pending_q) begin
                sh_num_q  <= stg_num_q;
                sh_en_q   <= stg_en_q;
                sh_dots_q <= stg_dots_q;
                sh_blz_q  <= stg_blz_q;
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.anodes     = anodes_q;
    assign bus.segments   = segments_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire
